// File: rtl/pll_reset_pkg.sv
// Shared types and sizing helpers for the PLL-driven reset sequencer.
// Holds the FSM state encoding and the qualification counter width function.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Counter must hold the larger terminal count; it is cleared on every state change.
  function automatic int cnt_width(input int stable_cycles, input int hold_cycles);
    int max_cycles;
    max_cycles = (stable_cycles > hold_cycles) ? stable_cycles : hold_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchroniser for asynchronous level inputs, cleared to 0 by reset.
// Latency STAGES clock edges; no flow control.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Qualifies PLL lock, then releases sys_reset one cycle before raising ready; counts lock losses.
// Lock loss reaches sys_reset SYNC_STAGES+1 edges after pll_locked falls; no flow control.
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int LOSS_CNT_W    = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pll_locked,
  input  logic                  loss_clear,
  output logic                  sys_reset,
  output logic                  ready,
  output logic                  lock_lost_sticky,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  localparam int CW = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX = '1;

  logic lock_s;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sys_reset_q, sys_reset_d;
  logic                  ready_q, ready_d;
  logic                  sticky_q, sticky_d;
  logic [LOSS_CNT_W-1:0] loss_count_q, loss_count_d;
  logic                  lock_loss;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clock(clock),
    .reset(reset),
    .d    (pll_locked),
    .q    (lock_s)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sys_reset_d  = sys_reset_q;
    ready_d      = ready_q;
    sticky_d     = sticky_q;
    loss_count_d = loss_count_q;
    lock_loss    = 1'b0;

    // Clear first so a coincident loss still records itself on top of it.
    if (loss_clear) begin
      sticky_d     = 1'b0;
      loss_count_d = '0;
    end

    case (state_q)
      HOLD: begin
        sys_reset_d = 1'b1;
        ready_d     = 1'b0;
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_LOCK: begin
        sys_reset_d = 1'b1;
        ready_d     = 1'b0;
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == STABLE_LAST) begin
          cnt_d       = '0;
          state_d     = RELEASE;
          sys_reset_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          lock_loss = 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          lock_loss = 1'b1;
        end
      end
      default: begin
        cnt_d       = '0;
        state_d     = HOLD;
        sys_reset_d = 1'b1;
        ready_d     = 1'b0;
      end
    endcase

    if (lock_loss) begin
      state_d     = HOLD;
      cnt_d       = '0;
      sys_reset_d = 1'b1;
      ready_d     = 1'b0;
      sticky_d    = 1'b1;
      if (loss_count_d != LOSS_MAX) begin
        loss_count_d = loss_count_d + LOSS_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= HOLD;
      cnt_q        <= '0;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
      sticky_q     <= 1'b0;
      loss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sys_reset_q  <= sys_reset_d;
      ready_q      <= ready_d;
      sticky_q     <= sticky_d;
      loss_count_q <= loss_count_d;
    end
  end

  assign sys_reset        = sys_reset_q;
  assign ready            = ready_q;
  assign lock_lost_sticky = sticky_q;
  assign loss_count       = loss_count_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4, LOSS_CNT_W=2.
module tb_pll_reset_seq;

  logic       clock;
  logic       reset;
  logic       pll_locked;
  logic       loss_clear;
  logic       sys_reset;
  logic       ready;
  logic       lock_lost_sticky;
  logic [1:0] loss_count;

  int vectors;
  int miscompares;

  pll_reset_seq #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(8),
    .HOLD_CYCLES  (4),
    .LOSS_CNT_W   (2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .pll_locked      (pll_locked),
    .loss_clear      (loss_clear),
    .sys_reset       (sys_reset),
    .ready           (ready),
    .lock_lost_sticky(lock_lost_sticky),
    .loss_count      (loss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Counts edges from HOLD entry: release on the 12th, ready on the 13th.
  task automatic relock_and_check(input string tag);
    repeat (11) tick();
    check({tag, "_srst_edge11"}, {7'd0, sys_reset}, 8'd1);
    tick();
    check({tag, "_srst_edge12"}, {7'd0, sys_reset}, 8'd0);
    check({tag, "_rdy_edge12"}, {7'd0, ready}, 8'd0);
    tick();
    check({tag, "_rdy_edge13"}, {7'd0, ready}, 8'd1);
    check({tag, "_srst_edge13"}, {7'd0, sys_reset}, 8'd0);
  endtask

  // Drops lock from RUN; loss_clear optionally pulsed on the edge that takes the loss.
  task automatic lose_lock(input string tag, input logic clr);
    pll_locked = 1'b0;
    tick();
    tick();
    check({tag, "_rdy_edge2"}, {7'd0, ready}, 8'd1);
    loss_clear = clr;
    tick();
    loss_clear = 1'b0;
    check({tag, "_srst_edge3"}, {7'd0, sys_reset}, 8'd1);
    check({tag, "_rdy_edge3"}, {7'd0, ready}, 8'd0);
    pll_locked = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    pll_locked  = 1'b1;
    loss_clear  = 1'b0;

    // Power-up
    repeat (5) tick();
    check("rst_srst", {7'd0, sys_reset}, 8'd1);
    check("rst_rdy", {7'd0, ready}, 8'd0);
    check("rst_sticky", {7'd0, lock_lost_sticky}, 8'd0);
    check("rst_count", {6'd0, loss_count}, 8'd0);
    reset = 1'b0;
    relock_and_check("pwrup");
    check("pwrup_count", {6'd0, loss_count}, 8'd0);
    check("pwrup_sticky", {7'd0, lock_lost_sticky}, 8'd0);

    // Glitch during WAIT_LOCK at counter=5 restarts qualification
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (9) tick();
    pll_locked = 1'b0;
    tick();
    tick();
    pll_locked = 1'b1;
    tick();
    check("glitch_srst_e12", {7'd0, sys_reset}, 8'd1);
    repeat (8) tick();
    check("glitch_srst_e20", {7'd0, sys_reset}, 8'd1);
    tick();
    check("glitch_srst_e21", {7'd0, sys_reset}, 8'd0);
    tick();
    check("glitch_rdy_e22", {7'd0, ready}, 8'd1);
    check("glitch_count", {6'd0, loss_count}, 8'd0);
    check("glitch_sticky", {7'd0, lock_lost_sticky}, 8'd0);

    // Loss in RUN, repeated to saturation: 1,2,3,3,3
    lose_lock("loss1", 1'b0);
    check("loss1_count", {6'd0, loss_count}, 8'd1);
    check("loss1_sticky", {7'd0, lock_lost_sticky}, 8'd1);
    relock_and_check("relock1");
    lose_lock("loss2", 1'b0);
    check("loss2_count", {6'd0, loss_count}, 8'd2);
    relock_and_check("relock2");
    lose_lock("loss3", 1'b0);
    check("loss3_count", {6'd0, loss_count}, 8'd3);
    relock_and_check("relock3");
    lose_lock("loss4", 1'b0);
    check("loss4_count", {6'd0, loss_count}, 8'd3);
    relock_and_check("relock4");
    lose_lock("loss5", 1'b0);
    check("loss5_count", {6'd0, loss_count}, 8'd3);
    check("loss5_sticky", {7'd0, lock_lost_sticky}, 8'd1);
    relock_and_check("relock5");

    // loss_clear coincident with a loss from a saturated count
    lose_lock("clrloss", 1'b1);
    check("clrloss_count", {6'd0, loss_count}, 8'd1);
    check("clrloss_sticky", {7'd0, lock_lost_sticky}, 8'd1);
    relock_and_check("relock6");

    // loss_clear alone
    loss_clear = 1'b1;
    tick();
    loss_clear = 1'b0;
    check("clr_count", {6'd0, loss_count}, 8'd0);
    check("clr_sticky", {7'd0, lock_lost_sticky}, 8'd0);
    check("clr_rdy", {7'd0, ready}, 8'd1);

    // Reset pulse in RUN with a non-zero count
    lose_lock("loss7", 1'b0);
    check("loss7_count", {6'd0, loss_count}, 8'd1);
    relock_and_check("relock7");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstrun_srst", {7'd0, sys_reset}, 8'd1);
    check("rstrun_rdy", {7'd0, ready}, 8'd0);
    check("rstrun_count", {6'd0, loss_count}, 8'd0);
    check("rstrun_sticky", {7'd0, lock_lost_sticky}, 8'd0);
    relock_and_check("rstrun");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
